nt_level_stepper: RTL and testbench
===================================

// Module: nt_level_stepper
// PURPOSE
//   Command-side driver for a neurotransmitter level integrator. Accepts a target level over a valid/ready
//   handshake and emits rate-limited inc/dec/fast single-cycle pulses until the integrator reaches the target.
//   Keeps a shadow copy of the integrator value so no feedback path is needed. Sits between behaviour logic
//   (e.g. a mood/action sequencer) and an N-bit nt level resource, replacing the combinational regulator path.
// PARAMETERS
//   N           7    level width; shadow and target are N bits
//   DEFAULT_VAL 96   shadow value after reset; must equal the DEFAULT_VAL of the driven integrator
//   FAST_STEP   3    step applied by the integrator when fast=1; must match the integrator
//   FAST_THRESH 16   |target-shadow| >= FAST_THRESH selects a fast step; must be >= FAST_STEP
//   TICK_DIV    4    one command opportunity every TICK_DIV clocks (>= 1)
//   HOLD_TICKS  2    ticks spent in HOLD after reaching the target, before a new target is accepted
// PORTS
//   clk           in   1   system clock
//   rst           in   1   reset, asynchronous, active-high
//   enable        in   1   0 freezes the prescaler and FSM; no pulses are issued
//   target        in   N   requested level
//   target_valid  in   1   target present
//   target_ready  out  1   high only in IDLE; transfer on valid&&ready at a rising edge
//   inc           out  1   one-cycle pulse: integrator +1 (or +FAST_STEP with fast)
//   dec           out  1   one-cycle pulse: integrator -1 (or -FAST_STEP with fast)
//   fast          out  1   qualifies inc/dec as a fast step; never high without inc or dec
//   settled       out  1   high in IDLE (shadow == last accepted target)
// BEHAVIOUR
//   Reset: inc=dec=fast=0, shadow=DEFAULT_VAL, tgt_q=DEFAULT_VAL, state=IDLE, prescaler=0,
//     target_ready=1, settled=1. Reset mid-operation aborts the move; pulses drop asynchronously.
//   Prescaler: counts 0..TICK_DIV-1 while enable=1 and wraps; tick = (count==TICK_DIV-1) && enable.
//   FSM:
//   - IDLE: on transfer, latch tgt_q. If target==shadow, stay IDLE; else go TRACK next cycle.
//   - TRACK: on each tick, with d = tgt_q - shadow (signed, N+1 bits):
//     - d >= FAST_THRESH: inc=1, fast=1, shadow += FAST_STEP
//     - 0 < d < FAST_THRESH: inc=1, shadow += 1
//     - d <= -FAST_THRESH: dec=1, fast=1, shadow -= FAST_STEP
//     - -FAST_THRESH < d < 0: dec=1, shadow -= 1
//     - Pulses are registered and appear in the cycle after the tick edge. Shadow updates on the same edge.
//     - If the updated shadow equals tgt_q, go HOLD with hold_cnt=0.
//   - HOLD: hold_cnt increments on each tick; at HOLD_TICKS ticks, go IDLE.
//   Latency: with a free-running prescaler, the first pulse occurs at the first tick after TRACK entry,
//     at most TICK_DIV+1 clocks after the transfer.
//   Invariants: inc&dec never both 1; no overshoot (FAST_THRESH >= FAST_STEP); shadow saturates at 0 and
//     2^N-1 as the integrator does.
//   target_valid outside IDLE is ignored and not queued; the source holds it until target_ready.
//   enable=0 during TRACK or HOLD pauses in place; the move resumes when enable returns to 1.
// CONFIGURATION
//   NT_STEPPER_DBG_EN defined: adds output port dbg_shadow[N-1:0], a registered copy of shadow.
//   Not defined: no such port; behaviour is otherwise identical.
// STRUCTURE
//   Shared include nt_defs.vh: FSM state encodings (ST_IDLE, ST_TRACK, ST_HOLD) and default widths/values
//     shared with the level integrator, so DEFAULT_VAL and FAST_STEP come from one definition.
//   One sub-module, nt_tick_prescaler (TICK_DIV, enable -> tick); the FSM, shadow and pulse registers stay
//     in this block.
// TESTING (N=7, DEFAULT_VAL=96, FAST_STEP=3, FAST_THRESH=16, TICK_DIV=4, HOLD_TICKS=2)
//   1. Assert rst for 3 clocks, then release -> inc=dec=fast=0, target_ready=1, settled=1, shadow=96.
//   2. Send target=100 -> 4 inc pulses, fast=0, spaced 4 clocks apart; shadow=100; ready=0 for 2 ticks of
//      HOLD; then ready=1 and settled=1.
//   3. Send target=64 -> 6 dec+fast pulses (96->78), then 14 plain dec pulses; 20 pulses total; shadow=64.
//   4. Send target=96 from shadow=96 -> accepted, no pulses, target_ready stays 1.
//   5. Raise target_valid during TRACK -> no transfer; the value is accepted on the first IDLE cycle.
//      Dropping enable mid-move -> no pulses while low; the pulse count resumes correctly afterwards.
//   6. Assert rst after the 2nd pulse of test 3 -> outputs 0 at once; after release shadow=96 and IDLE.
//      Compare against a reference integrator model at every step.

Source files
------------

// File: rtl/nt_level_stepper_pkg.sv
// Shared definitions for the nt level stepper and its integrator: state encodings and default widths/values,
// so DEFAULT_VAL and FAST_STEP come from a single definition.
package nt_level_stepper_pkg;

    localparam int NT_N           = 7;
    localparam int NT_DEFAULT_VAL = 96;
    localparam int NT_FAST_STEP   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } nt_state_e;

endpackage

// File: rtl/nt_level_stepper_prescaler.sv
// Command-opportunity prescaler: one tick every TICK_DIV enabled clocks; the count freezes while disabled.
module nt_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    assign o_tick = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/nt_level_stepper.sv
// Rate-limited inc/dec/fast pulse driver that walks a shadow copy of the nt level integrator to a target.
// Define NT_STEPPER_DBG_EN to expose dbg_shadow, a registered copy of the shadow value.
module nt_level_stepper
    import nt_level_stepper_pkg::*;
#(
    parameter int N           = NT_N,
    parameter int DEFAULT_VAL = NT_DEFAULT_VAL,
    parameter int FAST_STEP   = NT_FAST_STEP,
    parameter int FAST_THRESH = 16,
    parameter int TICK_DIV    = 4,
    parameter int HOLD_TICKS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] target,
    input  logic         target_valid,
    output logic         target_ready,
    output logic         inc,
    output logic         dec,
    output logic         fast,
    output logic         settled
`ifdef NT_STEPPER_DBG_EN
    ,
    output logic [N-1:0] dbg_shadow
`endif
);

    localparam int                NP1  = N + 1;
    localparam int                HW   = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic signed [N:0] THR  = NP1'(FAST_THRESH);
    localparam logic [N:0]        MAXV = {1'b0, {N{1'b1}}};

    nt_state_e         r_state, w_state_nx;
    logic [N-1:0]      r_shadow, w_shadow_nx;
    logic [N-1:0]      r_tgt, w_tgt_nx;
    logic [HW-1:0]     r_hold, w_hold_nx;
    logic [HW:0]       w_hold_inc;
    logic              r_inc, r_dec, r_fast;
    logic              w_inc_nx, w_dec_nx, w_fast_nx;
    logic              w_tick;
    logic signed [N:0] w_diff;
    logic [N:0]        w_up_fast;
    logic [N-1:0]      w_step_val;
    logic              w_step_inc, w_step_dec, w_step_fast;

    nt_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    assign w_diff     = $signed({1'b0, r_tgt}) - $signed({1'b0, r_shadow});
    assign w_up_fast  = {1'b0, r_shadow} + NP1'(FAST_STEP);
    assign w_hold_inc = {1'b0, r_hold} + 1'b1;

    // Step choice and shadow update; saturates at both rails exactly like the integrator.
    always_comb begin
        w_step_val  = r_shadow;
        w_step_inc  = 1'b0;
        w_step_dec  = 1'b0;
        w_step_fast = 1'b0;
        if (w_diff >= THR) begin
            w_step_inc  = 1'b1;
            w_step_fast = 1'b1;
            w_step_val  = (w_up_fast > MAXV) ? {N{1'b1}} : w_up_fast[N-1:0];
        end else if (w_diff > 0) begin
            w_step_inc = 1'b1;
            w_step_val = (r_shadow == {N{1'b1}}) ? r_shadow : r_shadow + 1'b1;
        end else if (w_diff <= -THR) begin
            w_step_dec  = 1'b1;
            w_step_fast = 1'b1;
            w_step_val  = (r_shadow < N'(FAST_STEP)) ? '0 : r_shadow - N'(FAST_STEP);
        end else if (w_diff < 0) begin
            w_step_dec = 1'b1;
            w_step_val = (r_shadow == '0) ? r_shadow : r_shadow - 1'b1;
        end
    end

    // A transfer in IDLE is taken even with enable low; TRACK/HOLD only advance on ticks,
    // and ticks never fire while disabled, so the move simply waits.
    always_comb begin
        w_state_nx  = r_state;
        w_shadow_nx = r_shadow;
        w_tgt_nx    = r_tgt;
        w_hold_nx   = r_hold;
        w_inc_nx    = 1'b0;
        w_dec_nx    = 1'b0;
        w_fast_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (target_valid) begin
                    w_tgt_nx = target;
                    if (target != r_shadow)
                        w_state_nx = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_tick) begin
                    w_inc_nx    = w_step_inc;
                    w_dec_nx    = w_step_dec;
                    w_fast_nx   = w_step_fast;
                    w_shadow_nx = w_step_val;
                    if (w_step_val == r_tgt) begin
                        w_state_nx = ST_HOLD;
                        w_hold_nx  = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_hold_nx = w_hold_inc[HW-1:0];
                    if (w_hold_inc >= (HW+1)'(HOLD_TICKS))
                        w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shadow <= N'(DEFAULT_VAL);
            r_tgt    <= N'(DEFAULT_VAL);
            r_hold   <= '0;
            r_inc    <= 1'b0;
            r_dec    <= 1'b0;
            r_fast   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_shadow <= w_shadow_nx;
            r_tgt    <= w_tgt_nx;
            r_hold   <= w_hold_nx;
            r_inc    <= w_inc_nx;
            r_dec    <= w_dec_nx;
            r_fast   <= w_fast_nx;
        end
    end

`ifdef NT_STEPPER_DBG_EN
    logic [N-1:0] r_dbg_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dbg_shadow <= N'(DEFAULT_VAL);
        else
            r_dbg_shadow <= r_shadow;
    end

    assign dbg_shadow = r_dbg_shadow;
`endif

    assign target_ready = (r_state == ST_IDLE);
    assign settled      = (r_state == ST_IDLE);
    assign inc          = r_inc;
    assign dec          = r_dec;
    assign fast         = r_fast;

endmodule

// File: tb/tb_nt_level_stepper.sv
// Randomized self-checking bench for nt_level_stepper against a pulse-plan and integrator reference model.
module tb_nt_level_stepper;

    localparam int N     = 7;
    localparam int DEF   = 96;
    localparam int FSTEP = 3;
    localparam int FTHR  = 16;
    localparam int TDIV  = 4;
    localparam int HOLD  = 2;
    localparam int MAXV  = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [N-1:0] target = '0;
    logic         target_valid = 1'b0;
    logic         target_ready, inc, dec, fast, settled;
`ifdef NT_STEPPER_DBG_EN
    logic [N-1:0] dbg_shadow;
`endif

    int checks = 0;
    int failures = 0;
    int m_integ;          // integrator driven by the DUT's observed pulses
    int m_shadow;         // level the plan says we end at
    int plan_dir[$];      // +1 inc, -1 dec
    int plan_fast[$];

    always #5 clk = ~clk;

    nt_level_stepper #(
        .N(N), .DEFAULT_VAL(DEF), .FAST_STEP(FSTEP), .FAST_THRESH(FTHR),
        .TICK_DIV(TDIV), .HOLD_TICKS(HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .target       (target),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .inc          (inc),
        .dec          (dec),
        .fast         (fast),
        .settled      (settled)
`ifdef NT_STEPPER_DBG_EN
        ,
        .dbg_shadow   (dbg_shadow)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pulse sequence straight from the step rules.
    function automatic void make_plan(input int from, input int to);
        int s;
        int d;
        plan_dir.delete();
        plan_fast.delete();
        s = from;
        while (s != to) begin
            d = to - s;
            if (d >= FTHR) begin
                plan_dir.push_back(1); plan_fast.push_back(1); s += FSTEP;
            end else if (d > 0) begin
                plan_dir.push_back(1); plan_fast.push_back(0); s += 1;
            end else if (d <= -FTHR) begin
                plan_dir.push_back(-1); plan_fast.push_back(1); s -= FSTEP;
            end else begin
                plan_dir.push_back(-1); plan_fast.push_back(0); s -= 1;
            end
        end
        m_shadow = to;
    endfunction

    function automatic void apply_pulse(input bit up, input bit f);
        int st;
        st = f ? FSTEP : 1;
        if (up) m_integ = (m_integ + st > MAXV) ? MAXV : m_integ + st;
        else    m_integ = (m_integ - st < 0) ? 0 : m_integ - st;
    endfunction

    task automatic send(input int tgt);
        @(negedge clk);
        chk("ready_pre", int'(target_ready), 1);
        target = N'(tgt);
        target_valid = 1'b1;
        @(posedge clk);
        #1 target_valid = 1'b0;
        make_plan(m_shadow, tgt);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("same_ready", int'(target_ready), 1);
            chk("same_settled", int'(settled), 1);
            chk("same_nopulse", int'(inc || dec || fast), 0);
        end
    endtask

    // Follows one move; pend>=0 raises a new target during TRACK, abort_at>0 resets after that pulse.
    task automatic run(input int pend, input bit drop_en, input int abort_at);
        int  cyc;
        int  last;
        int  npulse;
        bit  spacing_ok;
        cyc = 0; last = 0; npulse = 0; spacing_ok = 1'b1;
        while (plan_dir.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            chk("inc_dec_excl", int'(inc && dec), 0);
            chk("fast_qual", int'(fast && !inc && !dec), 0);
            chk("ready_busy", int'(target_ready), 0);
            if (inc || dec) begin
                npulse++;
                chk("pulse_dir", inc ? 1 : -1, plan_dir[0]);
                chk("pulse_fast", int'(fast), plan_fast[0]);
                void'(plan_dir.pop_front());
                void'(plan_fast.pop_front());
                apply_pulse(inc, fast);
                if (npulse == 1)
                    chk("first_lat", int'(cyc >= 2 && cyc <= TDIV + 1), 1);
                else if (spacing_ok)
                    chk("spacing", cyc - last, TDIV);
                last = cyc;
                spacing_ok = 1'b1;
                if (npulse == 1 && pend >= 0) begin
                    target = N'(pend);
                    target_valid = 1'b1;
                end
                if (npulse == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_inc", int'(inc), 0);
                    chk("rst_dec", int'(dec), 0);
                    chk("rst_fast", int'(fast), 0);
                    chk("rst_ready", int'(target_ready), 1);
                    chk("rst_settled", int'(settled), 1);
                    repeat (2) @(negedge clk);
                    rst = 1'b0;
                    m_integ = DEF;
                    m_shadow = DEF;
                    plan_dir.delete();
                    plan_fast.delete();
                    return;
                end
                if (drop_en && npulse == 3) begin
                    enable = 1'b0;
                    repeat (12) begin
                        @(negedge clk);
                        cyc++;
                        chk("paused", int'(inc || dec), 0);
                    end
                    enable = 1'b1;
                    spacing_ok = 1'b0;
                end
            end
        end
        chk("plan_done", plan_dir.size(), 0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            chk("hold_quiet", int'(inc || dec), 0);
        end while (!target_ready && cyc < 100);
        chk("hold_gap", cyc, HOLD * TDIV);
        chk("settled", int'(settled), 1);
        chk("integ", m_integ, m_shadow);
    endtask

    task automatic move(input int tgt);
        send(tgt);
        if (plan_dir.size() == 0) idle_check(6);
        else run(-1, 1'b0, 0);
    endtask

    initial begin
        int t;
        m_integ = DEF;
        m_shadow = DEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_rst_inc", int'(inc), 0);
        chk("in_rst_ready", int'(target_ready), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("post_rst_pulses", int'(inc || dec || fast), 0);
        chk("post_rst_ready", int'(target_ready), 1);
        chk("post_rst_settled", int'(settled), 1);

        move(96);                      // same as shadow: no move
        move(100);                     // 4 plain inc
        move(96);
        send(64); run(-1, 1'b1, 0);    // 6 fast + 14 plain dec, enable dropped mid-move
        send(100); run(80, 1'b0, 0);   // 80 presented during TRACK
        @(posedge clk);
        #1 target_valid = 1'b0;
        make_plan(m_shadow, 80);
        run(-1, 1'b0, 0);
        move(96);
        send(64); run(-1, 1'b0, 2);    // reset after 2nd pulse
        @(negedge clk);
        chk("abort_ready", int'(target_ready), 1);
        move(100);                     // must start again from 96
        move(0);
        move(MAXV);
        move(MAXV);
        repeat (8) begin
            t = int'($urandom_range(0, MAXV));
            move(t);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
